// File: rtl/usb_rx_sie_pkg.sv
// Types and constants shared between the receive SIE and the downstream USB controller.
package usb_rx_sie_pkg;

  typedef enum logic [1:0] {
    D_SE0 = 2'b00,
    D_J   = 2'b01,
    D_K   = 2'b10,
    D_SE1 = 2'b11
  } d_port_t;

  localparam int unsigned BYTE_W              = 8;
  localparam int unsigned STUFF_ONES          = 6;
  localparam int unsigned SYNC_ZEROS_MIN_DFLT = 5;

endpackage

// File: rtl/usb_rx_sie_if.sv
// Byte-level receive interface from the SIE to the controller.
interface usb_rx_sie_if;
  import usb_rx_sie_pkg::*;

  logic [BYTE_W-1:0] rx_data;
  logic              rx_valid;
  logic              rx_active;
  logic              rx_error;

  modport master (output rx_data, rx_valid, rx_active, rx_error);
  modport slave  (input  rx_data, rx_valid, rx_active, rx_error);

endinterface

// File: rtl/usb_rx_dpll.sv
// Bit-clock recovery from line transitions plus NRZI decode of the mid-cell sample.
module usb_rx_dpll
  import usb_rx_sie_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic    clk,
  input  logic    reset,
  input  d_port_t line_state,
  output logic    strobe,
  output d_port_t sym,
  output logic    nrzi_bit
);

  localparam int unsigned PW = $clog2(CLKS_PER_BIT);

  logic [PW-1:0] phase_q, phase_d;
  d_port_t       line_q, line_d;
  d_port_t       prev_q, prev_d;
  logic          strobe_q, strobe_d;
  logic          nrzi_q, nrzi_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      phase_q  <= '0;
      line_q   <= D_J;
      prev_q   <= D_J;
      strobe_q <= 1'b0;
      nrzi_q   <= 1'b0;
    end else begin
      phase_q  <= phase_d;
      line_q   <= line_d;
      prev_q   <= prev_d;
      strobe_q <= strobe_d;
      nrzi_q   <= nrzi_d;
    end
  end

  // Any line change realigns the phase; the strobe lands mid-cell.
  always_comb begin
    line_d = line_state;
    prev_d = prev_q;
    nrzi_d = nrzi_q;
    if (line_state != line_q) begin
      phase_d = '0;
    end else if (phase_q == PW'(CLKS_PER_BIT - 1)) begin
      phase_d = '0;
    end else begin
      phase_d = phase_q + PW'(1);
    end
    strobe_d = (phase_d == PW'(CLKS_PER_BIT / 2));
    if (strobe_d) begin
      nrzi_d = (line_state == prev_q);
      // After SE0 the bus idles in J, so that is the NRZI reference for the next packet.
      unique case (line_state)
        D_J, D_K: prev_d = line_state;
        D_SE0:    prev_d = D_J;
        default:  prev_d = prev_q;
      endcase
    end
  end

  assign strobe   = strobe_q;
  assign sym      = line_q;
  assign nrzi_bit = nrzi_q;

endmodule

// File: rtl/usb_rx_sie.sv
// Receive SIE: SYNC detection, bit unstuffing and LSB-first byte assembly.
module usb_rx_sie
  import usb_rx_sie_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT   = 16,
  parameter int unsigned SYNC_ZEROS_MIN = SYNC_ZEROS_MIN_DFLT
) (
  input  logic            clk,
  input  logic            reset,
  input  d_port_t         line_state,
  usb_rx_sie_if.master    rx
);

  localparam int unsigned ZW = 4;
  localparam int unsigned OW = 3;
  localparam int unsigned BW = 3;

  typedef enum logic [2:0] {S_IDLE, S_SYNC, S_DATA, S_ERR_WAIT, S_EOP} state_t;

  logic    strobe;
  d_port_t sym;
  logic    nrzi_bit;

  state_t            state_q, state_d;
  logic [ZW-1:0]     zeros_q, zeros_d;
  logic [OW-1:0]     ones_q, ones_d;
  logic [BW-1:0]     bits_q, bits_d;
  logic [BYTE_W-1:0] shift_q, shift_d;
  logic [BYTE_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic              active_q, active_d;
  logic              error_q, error_d;
  logic              err_c;

  usb_rx_dpll #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_dpll (
    .clk        (clk),
    .reset      (reset),
    .line_state (line_state),
    .strobe     (strobe),
    .sym        (sym),
    .nrzi_bit   (nrzi_bit)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      zeros_q  <= '0;
      ones_q   <= '0;
      bits_q   <= '0;
      shift_q  <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      active_q <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      zeros_q  <= zeros_d;
      ones_q   <= ones_d;
      bits_q   <= bits_d;
      shift_q  <= shift_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      active_q <= active_d;
      error_q  <= error_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    zeros_d  = zeros_q;
    ones_d   = ones_q;
    bits_d   = bits_q;
    shift_d  = shift_q;
    data_d   = data_q;
    valid_d  = 1'b0;
    error_d  = 1'b0;
    active_d = active_q;
    err_c    = 1'b0;
    if (strobe) begin
      unique case (state_q)
        S_IDLE: begin
          if (sym == D_K && !nrzi_bit) begin
            state_d = S_SYNC;
            zeros_d = ZW'(1);
          end
        end
        S_SYNC: begin
          if (sym != D_J && sym != D_K) begin
            state_d = S_IDLE;
          end else if (!nrzi_bit) begin
            if (zeros_q != '1) zeros_d = zeros_q + ZW'(1);
          end else if (zeros_q >= ZW'(SYNC_ZEROS_MIN)) begin
            state_d  = S_DATA;
            active_d = 1'b1;
            ones_d   = '0;
            bits_d   = '0;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_DATA: begin
          unique case (sym)
            D_SE0: begin
              if (bits_q == '0) state_d = S_EOP;
              else              err_c   = 1'b1;
            end
            D_SE1: err_c = 1'b1;
            default: begin
              // Bit after six ones is a stuff bit: a 0 is dropped, a 1 is a violation.
              if (ones_q == OW'(STUFF_ONES)) begin
                if (nrzi_bit) err_c  = 1'b1;
                else          ones_d = '0;
              end else begin
                shift_d = {nrzi_bit, shift_q[BYTE_W-1:1]};
                ones_d  = nrzi_bit ? ones_q + OW'(1) : '0;
                bits_d  = bits_q + BW'(1);
                if (bits_q == BW'(BYTE_W - 1)) begin
                  data_d  = shift_d;
                  valid_d = 1'b1;
                end
              end
            end
          endcase
          if (err_c) begin
            data_d  = '0;
            valid_d = 1'b1;
            error_d = 1'b1;
            state_d = S_ERR_WAIT;
          end
        end
        S_ERR_WAIT: begin
          if (sym == D_SE0) state_d = S_EOP;
        end
        S_EOP: begin
          if (sym != D_SE0) begin
            state_d  = S_IDLE;
            active_d = 1'b0;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign rx.rx_data   = data_q;
  assign rx.rx_valid  = valid_q;
  assign rx.rx_active = active_q;
  assign rx.rx_error  = error_q;

endmodule

// File: doc/usb_rx_sie.md
Name: usb_rx_sie

Overview:
Receive half of the serial interface engine (SIE). It sits directly upstream of the USB controller that decodes PIDs and tokens. It recovers bit timing from the synchronized D+/D- line state, detects SYNC, and performs NRZI decoding and bit unstuffing. It delivers bytes LSB-first on the controller's rx_data/rx_valid/rx_active/rx_error interface.

Parameters:
CLKS_PER_BIT, 16, clk cycles per USB bit (24 MHz / 1.5 Mbit/s low speed); must be even and >= 4
SYNC_ZEROS_MIN, 5, minimum NRZI zeros before the closing 1 for SYNC to be accepted (tolerates SYNC bits dropped by hubs)

Ports:
clk  input  1  system clock, 24 MHz
reset  input  1  reset; asynchronous and active-low (asserted at 0)
line_state  input  d_port_t  synchronized D+/D- (SE0, J, K, SE1)
rx_data  output  8  received byte, LSB = first bit on the wire
rx_valid  output  1  one-clk pulse: rx_data is valid
rx_active  output  1  high from SYNC accepted until EOP complete
rx_error  output  1  one-clk pulse, always coincident with rx_valid

Behaviour:
- Reset (asynchronous, reset==0): state IDLE; rx_data=0, rx_valid=0, rx_active=0, rx_error=0; phase counter=0; previous symbol=J; ones counter=0; bit counter=0.
- DPLL: phase counter runs 0..CLKS_PER_BIT-1 and wraps. Any change of line_state vs. the previous clk forces counter=0 on the next clk. Bit strobe fires when counter==CLKS_PER_BIT/2.
- At each strobe the sampled symbol is classified:
  - J/K: NRZI bit = 1 if equal to the previous sampled J/K symbol, 0 if different.
  - SE0: EOP candidate.
  - SE1: line error.
- States: IDLE, SYNC, DATA, ERR_WAIT, EOP.
- IDLE: first strobe sampling K (transition from J = NRZI 0) -> SYNC with zero count=1.
- SYNC:
  - Each 0 increments the zero count.
  - A 1 with zero count >= SYNC_ZEROS_MIN -> DATA; rx_active=1 from the next clk; bit counter and ones counter cleared.
  - A 1 with fewer zeros, or SE0/SE1 -> IDLE, with no rx_active and no pulses.
- DATA:
  - Each decoded bit shifts in at bit 7 of the shift register (LSB-first).
  - Ones counter increments on 1 and clears on 0.
  - After 6 consecutive 1s the next bit is a stuff bit: if 0, it is discarded and the ones counter cleared; if 1, it is a stuff error.
  - After the 8th data bit: rx_data=shift register and rx_valid=1 for exactly one clk, the clk after the strobe.
  - SE0 with bit counter==0 (byte aligned) -> EOP.
  - SE0 with bit counter!=0 is an alignment error; SE1 is a line error.
- Error handling (stuff, alignment, line): rx_valid=1 and rx_error=1 in the same clk, rx_data=0, then state ERR_WAIT. The controller relies on rx_error accompanying rx_valid to abort its token parse.
- ERR_WAIT: rx_active stays 1; no further rx_valid; any SE0 strobe -> EOP.
- EOP: waits for a strobe sampling J -> IDLE, rx_active=0 from the next clk, previous symbol=J. A strobe sampling K/SE1 -> IDLE as well (no extra error pulse).
- The stuff bit following the last data bit before EOP is still consumed; the ones counter does not span packets.
- Back-to-back packets: a new SYNC is recognised starting from the strobe after returning to IDLE.
- Reset asserted mid-packet aborts immediately: rx_active drops asynchronously and no pulse is emitted.
- Latency: rx_valid fires CLKS_PER_BIT/2 + 1 clks after the transition that starts the byte's last bit cell.

Decomposition:
- Package types (shared with the controller) owns d_port_t (SE0, J, K, SE1) and the constants STUFF_ONES=6 and SYNC_ZEROS_MIN default.
- State enum is local to the module.
- One sub-module, usb_rx_dpll: inputs clk, reset, line_state; outputs strobe, sym (d_port_t of the sampled symbol), nrzi_bit. It contains the phase counter, previous-symbol register and NRZI decode.
- The top level holds the SYNC/DATA/EOP FSM, unstuffing and byte assembly.

Test Plan:
- Idle J, then KJKJKJKK, then byte 0x69 (IN PID), then SE0 x2 bits, then J -> one rx_valid with rx_data=0x69, rx_error=0; rx_active high from SYNC end until 1 clk after the J strobe.
- SYNC with first two symbols dropped (KJKJKK), then 0xA5 -> accepted (5 zeros), rx_data=0xA5; SYNC KJKK (3 zeros) -> no rx_active, no pulses.
- Bytes 0xFF,0x01 with a stuffed 0 after the sixth 1 -> rx_data 0xFF then 0x01, stuff bit invisible; same stream with the stuff bit as 1 -> rx_valid+rx_error with rx_data=0, rx_active held until EOP.
- SE0 after 3 bits of the second byte -> first byte delivered, then rx_valid+rx_error pulse; rx_active falls after J.
- Line jitter: transitions shifted ±3 clks from nominal across a 3-byte packet -> all bytes correct.
- Reset pulled low midway through the second byte -> all outputs 0 asynchronously; next clean packet received correctly.
